// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Brief    : Round-robin sharing of one SPI controller between NUM_REQ
//            requesters, one frame per grant, with /CS demultiplexing.
// Revision : 1.0
// ============================================================================
module spi_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]             ack_o,
    output logic [FRAME_WIDTH-1:0]         rsp_data_o,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           busy_o,
    output logic                           spi_start_o,
    output logic [FRAME_WIDTH-1:0]         spi_data_o,
    input  logic                           spi_idle_i,
    input  logic [FRAME_WIDTH-1:0]         spi_data_i,
    input  logic                           spi_cs_i,
    output logic [NUM_REQ-1:0]             spi_cs_no
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last_q;
    logic [IDX_W-1:0]       winner;
    logic [2*NUM_REQ-1:0]   req_rot;
    int                     win_idx;

    // Rotate so bit k corresponds to requester (last_q+1+k) mod NUM_REQ;
    // scanning k downward leaves the lowest offset as the winner.
    always_comb begin
        req_rot = {req_i, req_i} >> (int'(last_q) + 1);
        winner  = last_q;
        win_idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_idx = int'(last_q) + 1 + k;
                if (win_idx >= NUM_REQ) begin
                    win_idx = win_idx - NUM_REQ;
                end
                winner = IDX_W'(win_idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= IDLE;
            grant_o    <= '0;
            ack_o      <= '0;
            spi_data_o <= '0;
            rsp_data_o <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
        end else begin
            ack_o <= '0;
            case (state)
                IDLE: begin
                    // Holding off until the controller is idle also covers a
                    // reset that landed in the middle of a frame.
                    if (spi_idle_i && (|req_i)) begin
                        grant_o    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                        spi_data_o <= req_data_i[winner*FRAME_WIDTH +: FRAME_WIDTH];
                        last_q     <= winner;
                        state      <= START;
                    end
                end
                START: begin
                    if (!spi_idle_i) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (spi_idle_i) begin
                        rsp_data_o <= spi_data_i;
                        ack_o      <= grant_o;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    grant_o <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign spi_start_o = (state == START);
    assign busy_o      = (state != IDLE);
    assign spi_cs_no   = {NUM_REQ{spi_cs_i}} | ~grant_o;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Brief    : Directed self-checking bench for spi_arbiter with a loopback
//            SPI controller model.
// Revision : 1.0
// ============================================================================
module tb_spi_arbiter;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic [3:0]  req_i = '0;
    logic [31:0] req_data_i = '0;
    logic [3:0]  ack_o;
    logic [7:0]  rsp_data_o;
    logic [3:0]  grant_o;
    logic        busy_o;
    logic        spi_start_o;
    logic [7:0]  spi_data_o;
    logic        spi_idle_i;
    logic [7:0]  spi_data_i;
    logic        spi_cs_i;
    logic [3:0]  spi_cs_no;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_arbiter #(.NUM_REQ(4), .FRAME_WIDTH(8)) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .req_i       (req_i),
        .req_data_i  (req_data_i),
        .ack_o       (ack_o),
        .rsp_data_o  (rsp_data_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .spi_start_o (spi_start_o),
        .spi_data_o  (spi_data_o),
        .spi_idle_i  (spi_idle_i),
        .spi_data_i  (spi_data_i),
        .spi_cs_i    (spi_cs_i),
        .spi_cs_no   (spi_cs_no)
    );

    // Controller model: 16-cycle frame, MISO looped to MOSI, never reset.
    logic       ctl_idle = 1'b1;
    logic       ctl_cs   = 1'b1;
    logic [7:0] ctl_shift = '0;
    logic [7:0] ctl_rx    = '0;
    int         ctl_cnt   = 0;
    int         frames    = 0;

    always @(posedge clk) begin
        if (ctl_idle) begin
            if (spi_start_o) begin
                ctl_idle  <= 1'b0;
                ctl_cs    <= 1'b0;
                ctl_shift <= spi_data_o;
                ctl_cnt   <= 16;
                frames    <= frames + 1;
            end
        end else begin
            ctl_cnt <= ctl_cnt - 1;
            if (ctl_cnt == 1) begin
                ctl_idle <= 1'b1;
                ctl_cs   <= 1'b1;
                ctl_rx   <= ctl_shift;
            end
        end
    end

    assign spi_idle_i = ctl_idle;
    assign spi_cs_i   = ctl_cs;
    assign spi_data_i = ctl_rx;

    int         oh_viol = 0;
    int         grants  = 0;
    logic [3:0] prev_grant = '0;

    always @(negedge clk) begin
        if (!$onehot0(grant_o) || !$onehot0(ack_o) || !$onehot0(~spi_cs_no))
            oh_viol = oh_viol + 1;
        if (grant_o != 4'b0 && prev_grant == 4'b0)
            grants = grants + 1;
        prev_grant = grant_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output logic [3:0] a, output logic [7:0] d, output logic [3:0] cs);
        a = '0; d = '0; cs = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cs = cs | ~spi_cs_no;
            if (ack_o != 4'b0) begin
                a = ack_o;
                d = rsp_data_o;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ni = 1'b0;
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);
    endtask

    logic [3:0] a;
    logic [7:0] d;
    logic [3:0] cs;
    logic       bad;
    int         fbase;
    logic [3:0] exp_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [3:0] exp_a3 [3] = '{4'b0010, 4'b1000, 4'b0010};
    logic [7:0] exp_d3 [3] = '{8'h5A, 8'hC3, 8'h5A};

    initial begin
        repeat (3) @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);
        chk("rst_grant", grant_o, 4'b0);
        chk("rst_ack", ack_o, 4'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_start", spi_start_o, 1'b0);
        chk("rst_rsp", rsp_data_o, 8'h00);
        chk("rst_spi_data", spi_data_o, 8'h00);
        chk("rst_cs", spi_cs_no, 4'hF);

        // Single request from requester 2
        req_data_i[23:16] = 8'hA5;
        req_i = 4'b0100;
        @(negedge clk);
        chk("t1_grant", grant_o, 4'b0100);
        chk("t1_start", spi_start_o, 1'b1);
        chk("t1_spi_data", spi_data_o, 8'hA5);
        repeat (2) @(negedge clk);
        chk("t1_start_le2", spi_start_o, 1'b0);
        wait_ack(a, d, cs);
        req_i = 4'b0;
        chk("t1_ack", a, 4'b0100);
        chk("t1_rsp", d, 8'hA5);
        chk("t1_cs_lines", cs, 4'b0100);
        @(negedge clk);
        chk("t1_idle_grant", grant_o, 4'b0);
        chk("t1_idle_busy", busy_o, 1'b0);

        // All requesting: fair rotation 0,1,2,3,0
        do_reset();
        fbase = frames;
        req_data_i = 32'h44332211;
        req_i = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ack(a, d, cs);
            if (k == 4) req_i = 4'b0;
            chk($sformatf("t2_ack%0d", k), a, exp_a[k]);
            chk($sformatf("t2_rsp%0d", k), d, exp_d[k]);
        end
        repeat (3) @(negedge clk);
        chk("t2_frames", frames - fbase, 5);

        // Requester 1 keeps requesting alongside 3: order 1,3,1
        do_reset();
        req_data_i = 32'hC3005A00;
        req_i = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            wait_ack(a, d, cs);
            if (k == 2) req_i = 4'b0;
            chk($sformatf("t3_ack%0d", k), a, exp_a3[k]);
            chk($sformatf("t3_rsp%0d", k), d, exp_d3[k]);
        end
        @(negedge clk);
        chk("t3_idle_grant", grant_o, 4'b0);

        // Data changed after grant is ignored
        do_reset();
        req_data_i = 32'h0000000F;
        req_i = 4'b0001;
        @(negedge clk);
        chk("t4_grant", grant_o, 4'b0001);
        @(negedge clk);
        req_data_i[7:0] = 8'hF0;
        wait_ack(a, d, cs);
        req_i = 4'b0;
        chk("t4_ack", a, 4'b0001);
        chk("t4_rsp", d, 8'h0F);

        // Reset while the controller is mid-frame
        do_reset();
        req_data_i = 32'h0000003C;
        req_i = 4'b0001;
        repeat (4) @(negedge clk);
        reset_ni = 1'b0;
        req_data_i[7:0] = 8'h96;
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        chk("t5_ctl_midframe", spi_idle_i, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 100 && !spi_idle_i; i++) begin
            @(negedge clk);
            if (!spi_idle_i && (grant_o != 4'b0 || ack_o != 4'b0 || busy_o))
                bad = 1'b1;
        end
        chk("t5_hold_off", bad, 1'b0);
        wait_ack(a, d, cs);
        req_i = 4'b0;
        chk("t5_ack", a, 4'b0001);
        chk("t5_rsp", d, 8'h96);

        // Request dropped during the frame
        do_reset();
        req_data_i = 32'h00770000;
        req_i = 4'b0100;
        repeat (4) @(negedge clk);
        chk("t6_busy", busy_o, 1'b1);
        req_i = 4'b0;
        wait_ack(a, d, cs);
        chk("t6_ack", a, 4'b0100);
        chk("t6_rsp", d, 8'h77);
        @(negedge clk);
        chk("t6_idle_grant", grant_o, 4'b0);
        chk("t6_idle_busy", busy_o, 1'b0);

        repeat (3) @(negedge clk);
        chk("onehot_viol", oh_viol, 0);
        chk("frames_per_grant", frames, grants);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one SPI controller (start/idle/data handshake, single /CS) between NUM_REQ requesters.
- Round-robin arbitration; each granted requester gets one complete SPI frame. The block latches that requester's tx word, sequences the controller's start pulse and waits for frame completion. It then returns the rx word with a one-cycle ack.
- Demultiplexes the controller's single /CS onto per-requester chip-select lines.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- FRAME_WIDTH, 32, SPI frame length in bits; must equal the controller's frame width.

Ports:
- clk_i  in  1  FPGA clock
- reset_ni  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  level request per requester
- req_data_i  in  NUM_REQ*FRAME_WIDTH  tx word per requester; slice k = bits [k*FRAME_WIDTH +: FRAME_WIDTH]
- ack_o  out  NUM_REQ  one-cycle completion pulse, one-hot
- rsp_data_o  out  FRAME_WIDTH  rx word of the last completed frame
- grant_o  out  NUM_REQ  one-hot owner of the current transaction; 0 when idle
- busy_o  out  1  1 whenever state != IDLE
- spi_start_o  out  1  to controller start input
- spi_data_o  out  FRAME_WIDTH  to controller tx data input
- spi_idle_i  in  1  from controller idle flag
- spi_data_i  in  FRAME_WIDTH  from controller rx data output
- spi_cs_i  in  1  controller /CS, active low
- spi_cs_no  out  NUM_REQ  per-requester /CS, active low

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; grant_o=0, ack_o=0, spi_start_o=0, busy_o=0.
  - rsp_data_o=0, spi_data_o=0.
  - RR pointer last_q=NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, START, BUSY, RESP.
- IDLE:
  - Grants only if spi_idle_i=1 and |req_i. This covers an arbiter reset while the controller is mid-frame: no grant until the controller reports idle.
  - Winner = first asserted req at index (last_q+1), (last_q+2), ... modulo NUM_REQ.
  - On grant: grant_o<=onehot(winner); spi_data_o<=req_data_i slice(winner); last_q<=winner; ->START.
- START:
  - spi_start_o=1 (decoded from state).
  - Stay while spi_idle_i=1. When spi_idle_i=0 (controller left its idle state) ->BUSY.
  - spi_start_o is therefore high at most until the cycle the controller is seen busy. It is never high when the controller re-enters idle, so no double frame.
- BUSY:
  - spi_start_o=0.
  - When spi_idle_i=1: rsp_data_o<=spi_data_i; ->RESP.
- RESP:
  - ack_o=grant_o for exactly one cycle.
  - Next cycle grant_o<=0, ->IDLE.
- Latency, req sampled in IDLE at cycle t with controller idle:
  - grant_o and spi_start_o high at t+1.
  - ack_o high exactly 1 cycle after the first cycle spi_idle_i=1 in BUSY.
  - rsp_data_o valid from the ack cycle and held until the next ack.
- Minimum gap between back-to-back frames: 1 IDLE cycle.
- Requester rules:
  - Holds req_i and its req_data_i until its ack.
  - Drops req_i in the cycle after ack; if still high it re-enters arbitration with lowest priority.
  - req_data_i is sampled only at grant; later changes have no effect on the frame.
- Deasserting req_i after grant does not abort the frame; the ack is still issued.
- Fairness: with all requesters asserting continuously, the grant order is 0,1,…,NUM_REQ-1,0,…
- Chip-select demux (combinational): spi_cs_no[k] = spi_cs_i | ~grant_o[k]. Non-granted lines stay 1; all lines are 1 in reset and IDLE.
- ack_o, grant_o and spi_cs_no are always one-hot or zero (spi_cs_no one-cold); never two set.
- Width rules:
  - last_q is $clog2(NUM_REQ) bits, wrap-around modulo NUM_REQ.
  - Modulo arithmetic must also be correct for non-power-of-2 NUM_REQ.

Test Plan (NUM_REQ=4, FRAME_WIDTH=8, real controller with CLOCK_DIVIDE=2, MISO looped to MOSI):
- Single request: req_i=4'b0100, data slice2=8'hA5 -> grant_o=4'b0100 one cycle later. spi_start_o high ≤2 cycles. Only spi_cs_no[2] toggles low. ack_o=4'b0100 for one cycle with rsp_data_o=8'hA5.
- All request continuously, slices 8'h11,8'h22,8'h33,8'h44 -> acks in order 0,1,2,3,0. rsp_data_o at each ack equals that requester's word. Exactly one controller frame per grant.
- Requester 1 holds req after ack while 3 also requests -> order 1,3,1, proving rotation.
- Change req_data_i slice 0 from 8'h0F to 8'hF0 one cycle after grant -> frame and rsp_data_o carry 8'h0F.
- Assert reset_ni=0 during BUSY, release while controller still mid-frame, req_i=4'b0001 -> no grant until spi_idle_i=1. Then a normal frame completes; ack_o stays 0 until that frame.
- Drop req_i during BUSY -> frame completes; ack_o still pulses for that requester; state returns to IDLE with grant_o=0.
